lsu_fence_sched: RTL

Scheduler between the LSU issue register and the execution units (load unit, store unit, icache invalidate port). It routes each accepted LSU exe-parameter to the load or store unit. It tracks outstanding loads and sequences FENCE/FENCE.I by draining all memory traffic before completion. A FENCE.I additionally runs an icache-invalidate handshake. A fence completes with a one-cycle writeback pulse for its rd.

---
 rtl/lsu_fence_sched_pkg.sv | 41 ++++
 rtl/lsu_fence_sched_ldcnt.sv | 43 ++++
 rtl/lsu_fence_sched.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/lsu_fence_sched_pkg.sv
// Shared definitions for the LSU fence scheduler: FSM states, exe-bundle layout
// and op-class decode helpers.
package lsu_fence_sched_pkg;

    localparam int RB_DEF    = 2;
    localparam int LU_DP_DEF = 4;
    localparam int OP_W      = 64;
    localparam int N_OPS     = 13;

    // Op-flag positions inside the op field; the bundle lists lb first, so lb is the MSB
    localparam int OPB_FENCE   = 0;
    localparam int OPB_FENCE_I = 1;
    localparam int OPB_SD      = 2;
    localparam int OPB_SW      = 3;
    localparam int OPB_SH      = 4;
    localparam int OPB_SB      = 5;
    localparam int OPB_LWU     = 6;
    localparam int OPB_LHU     = 7;
    localparam int OPB_LBU     = 8;
    localparam int OPB_LD      = 9;
    localparam int OPB_LW      = 10;
    localparam int OPB_LH      = 11;
    localparam int OPB_LB      = 12;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DISP,
        ST_DRAIN,
        ST_INV,
        ST_DONE
    } sched_state_e;

    function automatic logic is_load_op(input logic [N_OPS-1:0] ops);
        return |ops[OPB_LB:OPB_LWU];
    endfunction

    function automatic logic is_store_op(input logic [N_OPS-1:0] ops);
        return |ops[OPB_SB:OPB_SD];
    endfunction

endpackage

// File: rtl/lsu_fence_sched_ldcnt.sv
// Outstanding-load counter: +1 per load dispatch, -1 per load retirement,
// with full/zero flags for load gating and fence draining.
module lsu_ldcnt
    import lsu_fence_sched_pkg::*;
#(
    parameter int DEPTH = LU_DP_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic dec,
    output logic full,
    output logic zero
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && !dec) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (dec && !inc) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign full = (cnt_q == CNT_W'(DEPTH));
    assign zero = (cnt_q == '0);

    // A retirement with nothing outstanding means the load unit broke protocol
    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n) !(dec && zero));

endmodule

// File: rtl/lsu_fence_sched.sv
// Routes LSU exe-parameters to the load/store units and sequences FENCE/FENCE.I:
// drain all memory traffic, optionally invalidate the icache, then pulse a writeback.
module lsu_fence_sched
    import lsu_fence_sched_pkg::*;
#(
    parameter int RB     = RB_DEF,
    parameter int EXE_DW = N_OPS + 5 + RB + 2 * OP_W,
    parameter int LU_DP  = LU_DP_DEF
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              flush,
    input  logic              lsu_exeparam_valid,
    input  logic [EXE_DW-1:0] lsu_exeparam,
    output logic              lsu_exeparam_ready,
    output logic              lu_valid,
    input  logic              lu_ready,
    input  logic              lu_done,
    output logic              su_valid,
    input  logic              su_ready,
    input  logic              su_fifo_empty,
    output logic [EXE_DW-1:0] lsu_param_qout,
    output logic              icache_inv_req,
    input  logic              icache_inv_ack,
    output logic              fence_wb_valid,
    output logic [4+RB:0]     fence_wb_rd
);

    localparam int RD_W    = 5 + RB;
    localparam int RD_LSB  = 2 * OP_W;
    localparam int OPS_LSB = RD_LSB + RD_W;

    sched_state_e      state_q, state_d;
    logic [EXE_DW-1:0] param_q, param_d;
    logic              is_ld_q, is_ld_d;
    logic              fence_i_q, fence_i_d;
    logic              inv_flush_q, inv_flush_d;
    logic              started_q, started_d;

    logic [N_OPS-1:0]  ops_in;
    logic              in_load, in_store, in_fence;
    logic              ld_full, ld_zero, lu_hs;

    assign ops_in   = lsu_exeparam[OPS_LSB +: N_OPS];
    assign in_load  = is_load_op(ops_in);
    assign in_store = is_store_op(ops_in);
    assign in_fence = ops_in[OPB_FENCE] | ops_in[OPB_FENCE_I];
    assign lu_hs    = lu_valid & lu_ready;

    lsu_ldcnt #(
        .DEPTH (LU_DP)
    ) u_ldcnt (
        .clk   (CLK),
        .rst_n (RSTn),
        .inc   (lu_hs),
        .dec   (lu_done),
        .full  (ld_full),
        .zero  (ld_zero)
    );

    always_comb begin
        state_d            = state_q;
        param_d            = param_q;
        is_ld_d            = is_ld_q;
        fence_i_d          = fence_i_q;
        inv_flush_d        = inv_flush_q;
        started_d          = 1'b1;
        lsu_exeparam_ready = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                lsu_exeparam_ready = started_q & ~flush & ~(in_load & ld_full);
                if (lsu_exeparam_valid && lsu_exeparam_ready) begin
                    param_d = lsu_exeparam;
                    if (in_load) begin
                        state_d = ST_DISP;
                        is_ld_d = 1'b1;
                    end else if (in_fence) begin
                        state_d   = ST_DRAIN;
                        fence_i_d = ops_in[OPB_FENCE_I];
                    end else if (in_store) begin
                        state_d = ST_DISP;
                        is_ld_d = 1'b0;
                    end
                end
            end
            ST_DISP: begin
                if (is_ld_q ? lu_ready : su_ready) begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (ld_zero && su_fifo_empty) begin
                    state_d = fence_i_q ? ST_INV : ST_DONE;
                end
            end
            ST_INV: begin
                // The invalidate handshake must finish even if flushed; only the writeback is dropped
                if (flush) begin
                    inv_flush_d = 1'b1;
                end
                if (icache_inv_ack) begin
                    state_d     = (inv_flush_q || flush) ? ST_IDLE : ST_DONE;
                    inv_flush_d = 1'b0;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (flush && state_q != ST_INV) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q     <= ST_IDLE;
            param_q     <= '0;
            is_ld_q     <= 1'b0;
            fence_i_q   <= 1'b0;
            inv_flush_q <= 1'b0;
            started_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            param_q     <= param_d;
            is_ld_q     <= is_ld_d;
            fence_i_q   <= fence_i_d;
            inv_flush_q <= inv_flush_d;
            started_q   <= started_d;
        end
    end

    assign lu_valid       = (state_q == ST_DISP) & is_ld_q;
    assign su_valid       = (state_q == ST_DISP) & ~is_ld_q;
    assign icache_inv_req = (state_q == ST_INV);
    assign fence_wb_valid = (state_q == ST_DONE);
    assign fence_wb_rd    = (state_q == ST_DONE) ? param_q[RD_LSB +: RD_W] : '0;
    assign lsu_param_qout = param_q;

endmodule
